// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle iterative shifter (SRL, SLL, SRA).
//
// The operand is shifted a fixed step per clock so long shifts stall the
// pipeline rather than needing a full barrel shifter on the critical path.
//
// Optional feature: define SEQ_SHIFTER_FAST_EN to shift by min(4, cnt) per
// clock instead of by 1. Results are identical; only the latency changes.
//
// Parameters:
//   OPD_LENGTH      operand/result width (power of two, >= 8)
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   in_valid        request present
//   in_ready        unit can accept a request (IDLE only)
//   opd1            value to shift
//   opd2            shift amount, only [SHAMT_W-1:0] used
//   alu_op_select   001 SRL, 011 SLL, 111 SRA; anything else yields 0
//   out_valid       result present (DONE only)
//   out_ready       consumer takes the result
//   shifter_result  result, driven from the accumulator in every state
//   busy            high in SHIFT or DONE
module seq_shifter #(
  parameter int OPD_LENGTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPD_LENGTH-1:0] opd1,
  input  logic [OPD_LENGTH-1:0] opd2,
  input  logic [2:0]            alu_op_select,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPD_LENGTH-1:0] shifter_result,
  output logic                  busy
);

  localparam int SHAMT_W = $clog2(OPD_LENGTH);

  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [OPD_LENGTH-1:0] acc, acc_nxt;
  logic [SHAMT_W-1:0]    cnt, cnt_nxt;
  logic [2:0]            op, op_nxt;
  logic [SHAMT_W-1:0]    step;

  // Only the low SHAMT_W bits of the amount matter.
  logic unused_opd2;
  assign unused_opd2 = ^opd2[OPD_LENGTH-1:SHAMT_W];

  function automatic logic valid_op(input logic [2:0] sel);
    return (sel == OP_SRL) || (sel == OP_SLL) || (sel == OP_SRA);
  endfunction

  function automatic logic [OPD_LENGTH-1:0] shift_step(
    input logic [OPD_LENGTH-1:0] a,
    input logic [2:0]            sel,
    input logic [SHAMT_W-1:0]    s
  );
    logic signed [OPD_LENGTH-1:0] a_s;
    a_s = a;
    case (sel)
      OP_SLL:  return a << s;
      OP_SRL:  return a >> s;
      OP_SRA:  return a_s >>> s;
      default: return a;
    endcase
  endfunction

`ifdef SEQ_SHIFTER_FAST_EN
  // Never step past the remaining count, so cnt lands exactly on zero.
  assign step = (cnt > SHAMT_W'(4)) ? SHAMT_W'(4) : cnt;
`else
  assign step = SHAMT_W'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op    <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      op    <= op_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    op_nxt    = op;
    case (state)
      IDLE: begin
        if (in_valid) begin
          op_nxt  = alu_op_select;
          cnt_nxt = opd2[SHAMT_W-1:0];
          if (!valid_op(alu_op_select)) begin
            acc_nxt   = '0;
            state_nxt = DONE;
          end else begin
            acc_nxt   = opd1;
            state_nxt = (opd2[SHAMT_W-1:0] == '0) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_nxt = shift_step(acc, op, step);
        cnt_nxt = cnt - step;
        if (cnt_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode state only; no input reaches them combinationally.
  assign in_ready       = (state == IDLE);
  assign out_valid      = (state == DONE);
  assign busy           = (state != IDLE);
  assign shifter_result = acc;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] opd1 = '0;
  logic [W-1:0] opd2 = '0;
  logic [2:0]   alu_op_select = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] shifter_result;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t exp_q[$];

  seq_shifter #(.OPD_LENGTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .opd1           (opd1),
    .opd2           (opd2),
    .alu_op_select  (alu_op_select),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .shifter_result (shifter_result),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  // Reference: plain barrel shift of the whole amount in one go.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] sel);
    exp_t e;
    int k;
    logic signed [W-1:0] a_s;
    k = int'(b[2:0]);
    a_s = a;
    case (sel)
      3'b001: e.res = a >> k;
      3'b011: e.res = a << k;
      3'b111: e.res = a_s >>> k;
      default: e.res = '0;
    endcase
    if (sel != 3'b001 && sel != 3'b011 && sel != 3'b111) e.lat = 0;
`ifdef SEQ_SHIFTER_FAST_EN
    else e.lat = (k + 3) / 4;
`else
    else e.lat = k;
`endif
    return e;
  endfunction

  // Present one request at a negedge; it is accepted on the following posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel);
    @(negedge clk);
    exp_q.push_back(model(a, b, sel));
    opd1 = a; opd2 = b; alu_op_select = sel; in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, then complete the
  // handshake (optionally after a stall with out_ready low).
  task automatic collect(input int stall);
    exp_t e;
    int i;
    logic [W-1:0] held;
    e = exp_q.pop_front();
    i = 0;
    @(negedge clk);
    while (!out_valid && i < 64) begin
      @(negedge clk);
      i++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL collect_timeout: out_valid %b after %0d cycles, want 1", out_valid, i);
      return;
    end
    if (i != e.lat) begin
      miscompares++;
      $display("FAIL latency: got %0d want %0d", i, e.lat);
    end
    vectors++;
    if (shifter_result !== e.res) begin
      miscompares++;
      $display("FAIL result: got %h want %h", shifter_result, e.res);
    end
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL done_flags: in_ready %b busy %b want 0 1", in_ready, busy);
    end
    held = shifter_result;
    for (int c = 0; c < stall; c++) begin
      // Offer a new request while stalled; it must be ignored.
      in_valid = 1'b1; opd1 = 8'haa; opd2 = 8'h01; alu_op_select = 3'b011;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || shifter_result !== held || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: out_valid %b result %h in_ready %b want 1 %h 0",
                 out_valid, shifter_result, in_ready, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL after_handshake: out_valid %b in_ready %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel);
    issue(a, b, sel);
    collect(0);
  endtask

  task automatic test_reset;
    #3;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || shifter_result !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: in_ready %b out_valid %b busy %b result %h want 1 0 0 00",
               in_ready, out_valid, busy, shifter_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sll;
    run_op(8'h0f, 8'h03, 3'b011);
  endtask

  task automatic test_srl_sra;
    run_op(8'hf0, 8'h03, 3'b001);
    run_op(8'he0, 8'h03, 3'b111);
    run_op(8'h80, 8'h07, 3'b111);
    run_op(8'h81, 8'h07, 3'b001);
    run_op(8'hff, 8'h07, 3'b011);
  endtask

  task automatic test_zero_invalid_trunc;
    logic [W-1:0] vals [3];
    logic [2:0]   ops  [3];
    vals[0] = 8'h0f; vals[1] = 8'hf0; vals[2] = 8'he0;
    ops[0] = 3'b001; ops[1] = 3'b011; ops[2] = 3'b111;
    foreach (ops[o]) foreach (vals[v]) run_op(vals[v], 8'h00, ops[o]);
    run_op(8'h5a, 8'h03, 3'b000);
    run_op(8'hff, 8'h00, 3'b101);
    run_op(8'h0f, 8'h0b, 3'b011);
    run_op(8'hf0, 8'h08, 3'b001);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    issue(8'h0f, 8'h02, 3'b011);
    collect(5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_no_accept: out_valid %b in_ready %b want 0 1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    issue(8'h0f, 8'h05, 3'b011);
    void'(exp_q.pop_back());
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || shifter_result !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_op: in_ready %b out_valid %b busy %b result %h want 1 0 0 00",
               in_ready, out_valid, busy, shifter_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL post_reset: out_valid %b in_ready %b want 0 1", out_valid, in_ready);
      end
    end
    run_op(8'h0f, 8'h05, 3'b011);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 12; n++) begin
      logic [W-1:0] a, b;
      logic [2:0]   sel;
      a = W'($urandom);
      b = W'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: sel = 3'b001;
        1: sel = 3'b011;
        2: sel = 3'b111;
        default: sel = 3'b010;
      endcase
      run_op(a, b, sel);
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_srl_sra();
    test_zero_invalid_trunc();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
